// File: rtl/boot_run_controller.sv
// Life-cycle sequencer for the pipelined core: loads instruction BRAM, runs the core,
// then parks it and hands the data BRAM port to a read-only host.
module boot_run_controller #(
    parameter int WIDTH      = 32,
    parameter int IM_DEPTH   = 1024,
    parameter int MAX_CYCLES = 1048576
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      load_len,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    output logic             core_rst,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_im_addr,
    input  logic             core_dm_we,
    input  logic [WIDTH-1:0] core_dm_addr,
    input  logic [WIDTH-1:0] core_dm_wdata,
    output logic             im_we,
    output logic [WIDTH-1:0] im_addr,
    output logic [WIDTH-1:0] im_wdata,
    output logic             dm_we,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    input  logic [WIDTH-1:0] dm_rdata,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] rd_addr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       state,
    output logic [WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HALT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [15:0]      len_q, len_d;
    logic [WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             parked;

    assign parked = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            len_q         <= '0;
            cycle_count_q <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            len_q         <= len_d;
            cycle_count_q <= cycle_count_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        len_d         = len_q;
        cycle_count_d = cycle_count_q;
        // start takes priority over a same-cycle host read, which is dropped
        rd_valid_d    = parked && rd_req && !start;
        case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    if (load_len == 16'd0) begin
                        state_d       = S_RUN;
                        cycle_count_d = '0;
                    end else if (32'(load_len) > IM_DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_LOAD;
                        word_cnt_d = '0;
                        len_d      = load_len;
                    end
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (word_cnt_q == len_q - 16'd1) begin
                        state_d       = S_RUN;
                        cycle_count_d = '0;
                    end
                end
            end
            S_RUN: begin
                cycle_count_d = cycle_count_q + 1'b1;
                // done wins over a coincident timeout
                if (core_done)
                    state_d = S_HALT;
                else if (cycle_count_q == WIDTH'(MAX_CYCLES - 1))
                    state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core_rst = 1'b1;
        ld_ready = 1'b0;
        im_we    = 1'b0;
        im_addr  = '0;
        im_wdata = '0;
        dm_we    = 1'b0;
        dm_addr  = rd_addr;
        dm_wdata = '0;
        case (state_q)
            S_LOAD: begin
                ld_ready = 1'b1;
                im_we    = ld_valid;
                im_addr  = WIDTH'({word_cnt_q, 2'b00});
                im_wdata = ld_data;
            end
            S_RUN: begin
                core_rst = 1'b0;
                im_addr  = core_im_addr;
                dm_we    = core_dm_we;
                dm_addr  = core_dm_addr;
                dm_wdata = core_dm_wdata;
            end
            default: ;
        endcase
    end

    // BRAM read data lands the cycle after the address, alongside rd_valid
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_valid_q ? dm_rdata : '0;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_boot_run_controller.sv
// Randomized bench for boot_run_controller: scenario-level expectations plus
// a reference data memory built from the core's intended stores.
module tb_boot_run_controller;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int MAXC  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   load_len = '0;
    logic          ld_valid = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic          ld_ready;
    logic          core_rst;
    logic          core_done = 1'b0;
    logic [W-1:0]  core_im_addr = '0;
    logic          core_dm_we = 1'b0;
    logic [W-1:0]  core_dm_addr = '0;
    logic [W-1:0]  core_dm_wdata = '0;
    logic          im_we;
    logic [W-1:0]  im_addr, im_wdata;
    logic          dm_we;
    logic [W-1:0]  dm_addr, dm_wdata;
    logic [W-1:0]  dm_rdata;
    logic          rd_req = 1'b0;
    logic [W-1:0]  rd_addr = '0;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic [2:0]    state;
    logic [W-1:0]  cycle_count;

    boot_run_controller #(.WIDTH(W), .IM_DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .core_rst(core_rst), .core_done(core_done), .core_im_addr(core_im_addr),
        .core_dm_we(core_dm_we), .core_dm_addr(core_dm_addr), .core_dm_wdata(core_dm_wdata),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .state(state), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // data BRAM with a 1-cycle synchronous read
    logic [W-1:0] dm_mem [64];
    always @(posedge clk) begin
        if (dm_we) dm_mem[dm_addr[7:2]] <= dm_wdata;
        dm_rdata <= dm_mem[dm_addr[7:2]];
    end

    typedef struct { logic [W-1:0] a; logic [W-1:0] d; } wr_t;
    wr_t          log_q[$];
    logic [W-1:0] ref_dm [64];
    bit           ref_ok [64];
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sample instruction-BRAM writes just before the edge that commits them
    task automatic tick();
        #1;
        if (im_we === 1'b1) log_q.push_back('{im_addr, im_wdata});
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int len, input bit with_rd);
        log_q.delete();
        start = 1'b1; load_len = 16'(len);
        rd_req = with_rd; rd_addr = 32'h10;
        tick();
        start = 1'b0; rd_req = 1'b0;
        chk("start_state", state, (len == 0) ? 2 : (len > DEPTH) ? 4 : 1);
        chk("start_no_rd", rd_valid, 0);
    endtask

    task automatic do_load(input int len, input bit use_pat, input logic [31:0] pat, input bit with_rd);
        wr_t exp_q[$];
        int  acc = 0;
        int  cyc = 0;
        start_pulse(len, with_rd);
        while (acc < len && cyc < 200) begin
            ld_valid = use_pat ? pat[cyc % 32] : ($urandom % 3 != 0);
            ld_data  = $urandom;
            start    = ($urandom % 4 == 0);
            load_len = 16'($urandom % 8);
            #1;
            chk("ld_ready", ld_ready, 1);
            chk("ld_core_rst", core_rst, 1);
            chk("ld_dm_we", dm_we, 0);
            if (ld_valid) begin
                exp_q.push_back('{W'(acc * 4), ld_data});
                acc++;
            end
            tick();
            cyc++;
            chk("load_state", state, (acc == len) ? 2 : 1);
        end
        ld_valid = 1'b0; start = 1'b0;
        chk("load_words", acc, len);
        chk("im_we_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("im_addr", log_q[i].a, exp_q[i].a);
            chk("im_wdata", log_q[i].d, exp_q[i].d);
        end
        chk("run_core_rst", core_rst, 0);
    endtask

    task automatic run_core(input int ncyc, input bit done_last, input int exp_st);
        for (int c = 1; c <= ncyc; c++) begin
            logic [5:0] idx;
            idx           = (c == 1) ? 6'd4 : 6'($urandom);
            core_done     = done_last && (c == ncyc);
            core_im_addr  = $urandom;
            core_dm_we    = (c == 1) ? 1'b1 : 1'($urandom);
            core_dm_addr  = {24'd0, idx, 2'b00};
            core_dm_wdata = $urandom;
            rd_req        = 1'($urandom);
            rd_addr       = $urandom;
            start         = ($urandom % 4 == 0);
            load_len      = 16'($urandom % 8);
            #1;
            chk("run_dm_we", dm_we, core_dm_we);
            chk("run_dm_addr", dm_addr, core_dm_addr);
            chk("run_dm_wdata", dm_wdata, core_dm_wdata);
            chk("run_im_addr", im_addr, core_im_addr);
            chk("run_im_we", im_we, 0);
            chk("run_ld_ready", ld_ready, 0);
            chk("run_core_rst", core_rst, 0);
            chk("run_rd_valid", rd_valid, 0);
            chk("run_cnt", cycle_count, c - 1);
            if (core_dm_we) begin
                ref_dm[idx] = core_dm_wdata;
                ref_ok[idx] = 1'b1;
            end
            tick();
            if (c < ncyc) chk("run_state", state, 2);
        end
        core_done = 1'b0; core_dm_we = 1'b0; rd_req = 1'b0; start = 1'b0;
        chk("end_state", state, exp_st);
        chk("end_cnt", cycle_count, ncyc);
        chk("end_core_rst", core_rst, 1);
        chk("end_im_addr", im_addr, 0);
    endtask

    task automatic host_reads(input int n, input logic [W-1:0] first);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] a;
            int idx;
            idx = 4;
            for (int t = 0; t < 100; t++) begin
                int r;
                r = int'($urandom % 64);
                if (ref_ok[r]) begin idx = r; break; end
            end
            a = (i == 0) ? first : {24'd0, 6'(idx), 2'b00};
            rd_req = 1'b1; rd_addr = a;
            #1;
            chk("rd_dm_addr", dm_addr, a);
            chk("rd_dm_we", dm_we, 0);
            tick();
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, ref_dm[a[7:2]]);
        end
        rd_req = 1'b0;
        tick();
        chk("rd_idle", rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin ref_dm[i] = '0; ref_ok[i] = 1'b0; end

        // reset values
        @(posedge clk); @(posedge clk); #1;
        chk("rst_state", state, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_im_we", im_we, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cnt", cycle_count, 0);
        rst = 1'b1;
        tick();

        // reset asserted mid-load discards the load
        start_pulse(6, 0);
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin ld_data = $urandom; tick(); end
        rst = 1'b0;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_core_rst", core_rst, 1);
        chk("midrst_ld_ready", ld_ready, 0);
        chk("midrst_im_we", im_we, 0);
        ld_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        tick();
        do_load(4, 0, 0, 0);

        // run to done after 50 cycles, then host reads including 0x10
        run_core(50, 1, 3);
        host_reads(6, 32'h10);

        // start with a same-cycle read from HALT, valid pattern 1,0,1,1
        do_load(3, 1, 32'b1101, 1);
        run_core(MAXC, 0, 4);

        // load_len 0 from ERR goes straight to RUN; done coincides with timeout
        start_pulse(0, 0);
        chk("direct_run_cnt", cycle_count, 0);
        chk("direct_run_core_rst", core_rst, 0);
        run_core(MAXC, 1, 3);

        // oversize program
        start_pulse(DEPTH + 1, 0);
        chk("oversize_no_im_we", log_q.size(), 0);
        host_reads(3, 32'h10);

        for (int s = 0; s < 6; s++) begin
            do_load(int'($urandom_range(1, DEPTH)), 0, 0, 1'($urandom));
            run_core(int'($urandom_range(1, MAXC)), 1, 3);
            host_reads(4, 32'h10);
        end
        do_load(DEPTH, 0, 0, 0);
        run_core(MAXC, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
